// File: rtl/bram_loader_pkg.sv
`default_nettype none
//============================================================================
// Module      : bram_loader_pkg
// Description : Shared TPU constants and the BRAM loader FSM state type.
//               Imported by bram_loader and stride_addr_gen.
// Revision    : 1.0 - initial release
//============================================================================
package bram_loader_pkg;

    localparam int DWIDTH            = 8;   // element width in bits
    localparam int MAT_MUL_SIZE      = 4;   // elements per BRAM row
    localparam int AWIDTH            = 10;  // BRAM address width
    localparam int MASK_WIDTH        = 4;   // one write enable per element
    localparam int ADDR_STRIDE_WIDTH = 8;   // row-to-row address increment width
    localparam int ROW_CNT_WIDTH     = 8;   // row-count width

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

endpackage : bram_loader_pkg
`default_nettype wire

// File: rtl/stride_addr_gen.sv
`default_nettype none
//============================================================================
// Module      : stride_addr_gen
// Description : Row address generator for the BRAM loader. Loads the base
//               address, stride and row count on i_load, then on every
//               accepted beat (i_step) adds the stride to the address and
//               decrements the remaining-row counter. o_last flags that the
//               row currently addressed is the final one.
// Ports       : clk, reset        - clock, asynchronous active-high reset
//               i_load            - capture i_base / i_stride / i_num_rows
//               i_base            - first row address
//               i_stride          - address increment per row
//               i_num_rows        - number of rows in the transfer
//               i_step            - one row has been accepted
//               o_addr            - address for the current row
//               o_last            - remaining row count equals one
// Revision    : 1.0 - initial release
//============================================================================
module stride_addr_gen
    import bram_loader_pkg::*;
#(
    parameter int AWIDTH_P            = AWIDTH,
    parameter int ADDR_STRIDE_WIDTH_P = ADDR_STRIDE_WIDTH,
    parameter int ROW_CNT_WIDTH_P     = ROW_CNT_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_load,
    input  logic [AWIDTH_P-1:0]            i_base,
    input  logic [ADDR_STRIDE_WIDTH_P-1:0] i_stride,
    input  logic [ROW_CNT_WIDTH_P-1:0]     i_num_rows,
    input  logic                           i_step,
    output logic [AWIDTH_P-1:0]            o_addr,
    output logic                           o_last
);

    logic [AWIDTH_P-1:0]        w_stride_ext;
    logic [AWIDTH_P-1:0]        r_addr;
    logic [AWIDTH_P-1:0]        r_stride;
    logic [ROW_CNT_WIDTH_P-1:0] r_remaining;

    // Bring the stride to address width. A stride wider than the address
    // only matters modulo 2^AWIDTH, so its upper bits are dropped.
    generate
        if (ADDR_STRIDE_WIDTH_P >= AWIDTH_P) begin : g_stride_trunc
            assign w_stride_ext = i_stride[AWIDTH_P-1:0];
        end else begin : g_stride_ext
            assign w_stride_ext = {{(AWIDTH_P-ADDR_STRIDE_WIDTH_P){1'b0}}, i_stride};
        end
    endgenerate

    // Incremental address: one adder instead of base + k*stride. The add
    // wraps naturally at 2^AWIDTH.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr      <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_stride    <= w_stride_ext;
            r_remaining <= i_num_rows;
        end else if (i_step) begin
            r_addr      <= r_addr + r_stride;
            r_remaining <= r_remaining - ROW_CNT_WIDTH_P'(1);
        end
    end

    assign o_addr = r_addr;
    assign o_last = (r_remaining == ROW_CNT_WIDTH_P'(1));

endmodule : stride_addr_gen
`default_nettype wire

// File: rtl/bram_loader.sv
`default_nettype none
//============================================================================
// Module      : bram_loader
// Description : Upstream fill stage for the accelerator BRAMs. Accepts a
//               valid/ready stream of rows and writes them through the
//               external write port of BRAM A or BRAM B at base + k*stride,
//               then pulses done for one cycle.
// Ports       : clk, reset               - clock, asynchronous active-high reset
//               start                    - one-cycle request, config sampled here
//               target_b                 - 0: BRAM A, 1: BRAM B
//               base_addr/addr_stride    - first address and per-row increment
//               num_rows                 - rows to write (0: immediate done)
//               abort                    - synchronous cancel while loading
//               in_valid/in_ready        - row stream handshake
//               in_data/in_mask          - row payload and element enables
//               bram_*_a_ext/bram_*_b_ext- registered write port to A and B
//               busy                     - LOAD or DONE
//               done                     - one-cycle completion pulse
// Revision    : 1.0 - initial release
//============================================================================
module bram_loader
    import bram_loader_pkg::*;
#(
    parameter int DWIDTH_P            = DWIDTH,
    parameter int MAT_MUL_SIZE_P      = MAT_MUL_SIZE,
    parameter int AWIDTH_P            = AWIDTH,
    parameter int MASK_WIDTH_P        = MASK_WIDTH,
    parameter int ADDR_STRIDE_WIDTH_P = ADDR_STRIDE_WIDTH,
    parameter int ROW_CNT_WIDTH_P     = ROW_CNT_WIDTH
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                target_b,
    input  logic [AWIDTH_P-1:0]                 base_addr,
    input  logic [ADDR_STRIDE_WIDTH_P-1:0]      addr_stride,
    input  logic [ROW_CNT_WIDTH_P-1:0]          num_rows,
    input  logic                                abort,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [MAT_MUL_SIZE_P*DWIDTH_P-1:0]  in_data,
    input  logic [MASK_WIDTH_P-1:0]             in_mask,
    output logic [AWIDTH_P-1:0]                 bram_addr_a_ext,
    output logic [AWIDTH_P-1:0]                 bram_addr_b_ext,
    output logic [MAT_MUL_SIZE_P*DWIDTH_P-1:0]  bram_wdata_a_ext,
    output logic [MAT_MUL_SIZE_P*DWIDTH_P-1:0]  bram_wdata_b_ext,
    output logic [MASK_WIDTH_P-1:0]             bram_we_a_ext,
    output logic [MASK_WIDTH_P-1:0]             bram_we_b_ext,
    output logic                                busy,
    output logic                                done
);

    load_state_t r_state;
    load_state_t w_next_state;

    logic                               r_target_b;
    logic [AWIDTH_P-1:0]                r_wr_addr;
    logic [MAT_MUL_SIZE_P*DWIDTH_P-1:0] r_wr_data;
    logic [MASK_WIDTH_P-1:0]            r_we_a;
    logic [MASK_WIDTH_P-1:0]            r_we_b;

    logic                w_in_ready;
    logic                w_start_accept;
    logic                w_beat;
    logic [AWIDTH_P-1:0] w_row_addr;
    logic                w_row_last;

    // Ready depends on the state register alone, keeping in_valid off any
    // combinational path to in_ready.
    assign w_in_ready     = (r_state == ST_LOAD);
    assign w_start_accept = start && (r_state == ST_IDLE);
    // Abort wins over a beat offered in the same cycle.
    assign w_beat         = in_valid && w_in_ready && !abort;

    stride_addr_gen #(
        .AWIDTH_P            (AWIDTH_P),
        .ADDR_STRIDE_WIDTH_P (ADDR_STRIDE_WIDTH_P),
        .ROW_CNT_WIDTH_P     (ROW_CNT_WIDTH_P)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_start_accept),
        .i_base     (base_addr),
        .i_stride   (addr_stride),
        .i_num_rows (num_rows),
        .i_step     (w_beat),
        .o_addr     (w_row_addr),
        .o_last     (w_row_last)
    );

    //------------------------------------------------------------------
    // FSM
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (num_rows == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    w_next_state = ST_IDLE;
                end else if (w_beat && w_row_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Target select and registered write port
    //------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target_b <= 1'b0;
        end else if (w_start_accept) begin
            r_target_b <= target_b;
        end
    end

    // Address and data hold between beats; only the enables return to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_we_a    <= '0;
            r_we_b    <= '0;
        end else if (w_beat) begin
            r_wr_addr <= w_row_addr;
            r_wr_data <= in_data;
            r_we_a    <= r_target_b ? '0 : in_mask;
            r_we_b    <= r_target_b ? in_mask : '0;
        end else begin
            r_we_a    <= '0;
            r_we_b    <= '0;
        end
    end

    assign in_ready         = w_in_ready;
    assign bram_addr_a_ext  = r_wr_addr;
    assign bram_addr_b_ext  = r_wr_addr;
    assign bram_wdata_a_ext = r_wr_data;
    assign bram_wdata_b_ext = r_wr_data;
    assign bram_we_a_ext    = r_we_a;
    assign bram_we_b_ext    = r_we_b;
    assign busy             = (r_state != ST_IDLE);
    assign done             = (r_state == ST_DONE);

endmodule : bram_loader
`default_nettype wire

// File: tb/tb_bram_loader.sv
`default_nettype none
//============================================================================
// Module      : tb_bram_loader
// Description : Self-checking bench for bram_loader. A table of directed
//               vectors covers the straight-line transfers (target A, target
//               B with address wrap, zero-row request); hand-written
//               sequences cover stalls with mixed masks, abort, a start
//               while busy and an asynchronous mid-transfer reset.
// Revision    : 1.0 - initial release
//============================================================================
module tb_bram_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic        target_b;
    logic [9:0]  base_addr;
    logic [7:0]  addr_stride;
    logic [7:0]  num_rows;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_mask;
    logic [9:0]  bram_addr_a_ext;
    logic [9:0]  bram_addr_b_ext;
    logic [31:0] bram_wdata_a_ext;
    logic [31:0] bram_wdata_b_ext;
    logic [3:0]  bram_we_a_ext;
    logic [3:0]  bram_we_b_ext;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    bram_loader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .target_b         (target_b),
        .base_addr        (base_addr),
        .addr_stride      (addr_stride),
        .num_rows         (num_rows),
        .abort            (abort),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_data          (in_data),
        .in_mask          (in_mask),
        .bram_addr_a_ext  (bram_addr_a_ext),
        .bram_addr_b_ext  (bram_addr_b_ext),
        .bram_wdata_a_ext (bram_wdata_a_ext),
        .bram_wdata_b_ext (bram_wdata_b_ext),
        .bram_we_a_ext    (bram_we_a_ext),
        .bram_we_b_ext    (bram_we_b_ext),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        tgt;
        logic [9:0]  base;
        logic [7:0]  stride;
        logic [7:0]  nrows;
        logic        abort;
        logic        valid;
        logic [31:0] data;
        logic [3:0]  mask;
        logic        e_ready;
        logic        e_busy;
        logic        e_done;
        logic [3:0]  e_we_a;
        logic [3:0]  e_we_b;
        logic [9:0]  e_addr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t vecs[12];

    function automatic vec_t mk(
        input logic st, input logic tg, input logic [9:0] ba, input logic [7:0] sd,
        input logic [7:0] nr, input logic ab, input logic vl, input logic [31:0] dt,
        input logic [3:0] mk_, input logic rdy, input logic bsy, input logic dn,
        input logic [3:0] wa, input logic [3:0] wb, input logic [9:0] ad, input logic [31:0] wd);
        vec_t v;
        v.start = st; v.tgt = tg; v.base = ba; v.stride = sd; v.nrows = nr;
        v.abort = ab; v.valid = vl; v.data = dt; v.mask = mk_;
        v.e_ready = rdy; v.e_busy = bsy; v.e_done = dn; v.e_we_a = wa; v.e_we_b = wb;
        v.e_addr = ad; v.e_wdata = wd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outs(input string tag, input logic rdy, input logic bsy, input logic dn,
                              input logic [3:0] wa, input logic [3:0] wb,
                              input logic [9:0] ad, input logic [31:0] wd);
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(rdy));
        chk({tag, ".busy"},     32'(busy),     32'(bsy));
        chk({tag, ".done"},     32'(done),     32'(dn));
        chk({tag, ".we_a"},     32'(bram_we_a_ext), 32'(wa));
        chk({tag, ".we_b"},     32'(bram_we_b_ext), 32'(wb));
        chk({tag, ".addr_a"},   32'(bram_addr_a_ext), 32'(ad));
        chk({tag, ".addr_b"},   32'(bram_addr_b_ext), 32'(ad));
        chk({tag, ".wdata_a"},  bram_wdata_a_ext, wd);
        chk({tag, ".wdata_b"},  bram_wdata_b_ext, wd);
    endtask

    task automatic drive(input logic st, input logic tg, input logic [9:0] ba,
                         input logic [7:0] sd, input logic [7:0] nr, input logic ab,
                         input logic vl, input logic [31:0] dt, input logic [3:0] mk_);
        start = st; target_b = tg; base_addr = ba; addr_stride = sd; num_rows = nr;
        abort = ab; in_valid = vl; in_data = dt; in_mask = mk_;
    endtask

    // Advance one clock and settle away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
    endtask

    logic [3:0]  masks4 [4];
    logic [9:0]  exp_addr;
    logic [9:0]  prev_addr;
    logic [31:0] prev_data;
    logic [31:0] beat_data;

    initial begin
        vecs[0]  = mk(1,0,10'h010,8'h04,8'd3,0,0,32'h0,       4'h0, 1,1,0,4'h0,4'h0,10'h000,32'h0);
        vecs[1]  = mk(0,0,10'h000,8'h00,8'd0,0,1,32'h11111111,4'hF, 1,1,0,4'hF,4'h0,10'h010,32'h11111111);
        vecs[2]  = mk(0,0,10'h000,8'h00,8'd0,0,1,32'h22222222,4'hF, 1,1,0,4'hF,4'h0,10'h014,32'h22222222);
        vecs[3]  = mk(0,0,10'h000,8'h00,8'd0,0,1,32'h33333333,4'hF, 0,1,1,4'hF,4'h0,10'h018,32'h33333333);
        vecs[4]  = mk(0,0,10'h000,8'h00,8'd0,0,0,32'h0,       4'h0, 0,0,0,4'h0,4'h0,10'h018,32'h33333333);
        vecs[5]  = mk(1,1,10'h3FE,8'h01,8'd3,0,0,32'h0,       4'h0, 1,1,0,4'h0,4'h0,10'h018,32'h33333333);
        vecs[6]  = mk(0,0,10'h000,8'h00,8'd0,0,1,32'hA0A0A0A0,4'h5, 1,1,0,4'h0,4'h5,10'h3FE,32'hA0A0A0A0);
        vecs[7]  = mk(0,0,10'h000,8'h00,8'd0,0,1,32'hB1B1B1B1,4'h3, 1,1,0,4'h0,4'h3,10'h3FF,32'hB1B1B1B1);
        vecs[8]  = mk(0,0,10'h000,8'h00,8'd0,0,1,32'hC2C2C2C2,4'hF, 0,1,1,4'h0,4'hF,10'h000,32'hC2C2C2C2);
        vecs[9]  = mk(0,0,10'h000,8'h00,8'd0,0,0,32'h0,       4'h0, 0,0,0,4'h0,4'h0,10'h000,32'hC2C2C2C2);
        // Zero-row request with a beat offered: immediate done, nothing written.
        vecs[10] = mk(1,0,10'h155,8'h09,8'd0,0,1,32'hDEADBEEF,4'hF, 0,1,1,4'h0,4'h0,10'h000,32'hC2C2C2C2);
        vecs[11] = mk(0,0,10'h000,8'h00,8'd0,0,1,32'hDEADBEEF,4'hF, 0,0,0,4'h0,4'h0,10'h000,32'hC2C2C2C2);

        masks4[0] = 4'h1; masks4[1] = 4'h0; masks4[2] = 4'h8; masks4[3] = 4'hF;

        // Reset
        reset = 1'b1;
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        tick();
        check_outs("reset", 0, 0, 0, 4'h0, 4'h0, 10'h000, 32'h0);
        reset = 1'b0;
        tick();

        // Table-driven transfers
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].start, vecs[i].tgt, vecs[i].base, vecs[i].stride, vecs[i].nrows,
                  vecs[i].abort, vecs[i].valid, vecs[i].data, vecs[i].mask);
            tick();
            check_outs($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_busy, vecs[i].e_done,
                       vecs[i].e_we_a, vecs[i].e_we_b, vecs[i].e_addr, vecs[i].e_wdata);
        end

        // Stalled stream with mixed masks: base 0x100, stride 0x20, 4 rows, target A
        prev_addr = 10'h000;
        prev_data = 32'hC2C2C2C2;
        drive(1'b1, 1'b0, 10'h100, 8'h20, 8'd4, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        check_outs("stall.start", 1, 1, 0, 4'h0, 4'h0, prev_addr, prev_data);
        for (int k = 0; k < 4; k++) begin
            idle_cycle();
            check_outs($sformatf("stall.gap%0d", k), 1, 1, 0, 4'h0, 4'h0, prev_addr, prev_data);
            beat_data = 32'h01010101 * (k + 1);
            exp_addr  = 10'(32'h100 + k * 32'h20);
            drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b1, beat_data, masks4[k]);
            tick();
            check_outs($sformatf("stall.beat%0d", k), (k != 3), 1, (k == 3),
                       masks4[k], 4'h0, exp_addr, beat_data);
            prev_addr = exp_addr;
            prev_data = beat_data;
        end
        idle_cycle();
        check_outs("stall.end", 0, 0, 0, 4'h0, 4'h0, prev_addr, prev_data);

        // Abort after 2 of 5 rows, with a beat offered in the abort cycle
        drive(1'b1, 1'b1, 10'h050, 8'h02, 8'd5, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        check_outs("abort.start", 1, 1, 0, 4'h0, 4'h0, prev_addr, prev_data);
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b1, 32'h5A5A0000, 4'hF);
        tick();
        check_outs("abort.beat0", 1, 1, 0, 4'h0, 4'hF, 10'h050, 32'h5A5A0000);
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b1, 32'h5A5A0001, 4'hF);
        tick();
        check_outs("abort.beat1", 1, 1, 0, 4'h0, 4'hF, 10'h052, 32'h5A5A0001);
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b1, 1'b1, 32'h99999999, 4'hF);
        tick();
        check_outs("abort.cut", 0, 0, 0, 4'h0, 4'h0, 10'h052, 32'h5A5A0001);
        idle_cycle();
        check_outs("abort.after", 0, 0, 0, 4'h0, 4'h0, 10'h052, 32'h5A5A0001);
        drive(1'b1, 1'b0, 10'h200, 8'h03, 8'd2, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        check_outs("restart.start", 1, 1, 0, 4'h0, 4'h0, 10'h052, 32'h5A5A0001);
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b1, 32'h12345678, 4'hF);
        tick();
        check_outs("restart.beat0", 1, 1, 0, 4'hF, 4'h0, 10'h200, 32'h12345678);
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b1, 32'h9ABCDEF0, 4'hF);
        tick();
        check_outs("restart.beat1", 0, 1, 1, 4'hF, 4'h0, 10'h203, 32'h9ABCDEF0);
        idle_cycle();
        check_outs("restart.end", 0, 0, 0, 4'h0, 4'h0, 10'h203, 32'h9ABCDEF0);

        // Start while busy is ignored; then asynchronous reset mid-transfer
        drive(1'b1, 1'b0, 10'h080, 8'h01, 8'd4, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b1, 32'hCAFE0000, 4'hF);
        tick();
        check_outs("busy.beat0", 1, 1, 0, 4'hF, 4'h0, 10'h080, 32'hCAFE0000);
        drive(1'b1, 1'b1, 10'h300, 8'h07, 8'd1, 1'b0, 1'b1, 32'hCAFE0001, 4'hF);
        tick();
        check_outs("busy.restart_ignored", 1, 1, 0, 4'hF, 4'h0, 10'h081, 32'hCAFE0001);
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        #2;
        reset = 1'b1;
        #1;
        check_outs("async_reset", 0, 0, 0, 4'h0, 4'h0, 10'h000, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 1'b1, 10'h005, 8'h01, 8'd1, 1'b0, 1'b0, 32'h0, 4'h0);
        tick();
        check_outs("post_reset.start", 1, 1, 0, 4'h0, 4'h0, 10'h000, 32'h0);
        drive(1'b0, 1'b0, 10'h0, 8'h0, 8'h0, 1'b0, 1'b1, 32'h0BADF00D, 4'h6);
        tick();
        check_outs("post_reset.beat", 0, 1, 1, 4'h0, 4'h6, 10'h005, 32'h0BADF00D);
        idle_cycle();
        check_outs("post_reset.end", 0, 0, 0, 4'h0, 4'h0, 10'h005, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bram_loader
`default_nettype wire

// File: doc/bram_loader.md
# bram_loader

- Upstream fill stage for the accelerator's BRAMs.
- Accepts a valid/ready stream of row vectors from the host-side DMA and writes them into matrix BRAM A (activations) or matrix BRAM B (weights).
- Drives the external (port 1) write side of the chosen BRAM.
- Fills rows at a programmable base address and stride, then pulses `done` so software can set `start_tpu`.

## Interface
Parameters:
- `DWIDTH`, 8, element width in bits
- `MAT_MUL_SIZE`, 4, elements per BRAM row
- `AWIDTH`, 10, BRAM address width
- `MASK_WIDTH`, 4, byte-enable width (= `MAT_MUL_SIZE`)
- `ADDR_STRIDE_WIDTH`, 8, stride width
- `ROW_CNT_WIDTH`, 8, row-count width

Ports:
- `clk` in 1 — single clock; everything in this block is on it
- `reset` in 1 — asynchronous, active-high
- `start` in 1 — one-cycle request; config is sampled in this cycle
- `target_b` in 1 — 0 selects BRAM A, 1 selects BRAM B
- `base_addr` in `AWIDTH` — first row address
- `addr_stride` in `ADDR_STRIDE_WIDTH` — address increment per row
- `num_rows` in `ROW_CNT_WIDTH` — rows to write
- `abort` in 1 — synchronous cancel
- `in_valid` in 1 — stream beat valid
- `in_ready` out 1 — stream beat ready
- `in_data` in `MAT_MUL_SIZE*DWIDTH` — row payload
- `in_mask` in `MASK_WIDTH` — per-element write enable
- `bram_addr_a_ext`, `bram_addr_b_ext` out `AWIDTH` each — write address
- `bram_wdata_a_ext`, `bram_wdata_b_ext` out `MAT_MUL_SIZE*DWIDTH` each — write data
- `bram_we_a_ext`, `bram_we_b_ext` out `MASK_WIDTH` each — write enables
- `busy` out 1 — transfer in progress
- `done` out 1 — one-cycle completion pulse

## Operation
FSM states:
- IDLE: `in_ready`=0.
  - `start`=1 latches `target_b`, `base_addr`, `addr_stride`, `num_rows`.
  - Goes to LOAD, or to DONE if `num_rows`==0.
- LOAD: `in_ready`=1. A beat is accepted when `in_valid && in_ready`.
  - Each accepted beat k (k = 0..num_rows-1) is written at `base_addr + k*addr_stride`, truncated mod 2^AWIDTH (wraps silently).
  - The address is generated incrementally, never by a multiply.
  - Accepting beat num_rows-1 → DONE.
  - `abort`=1 → IDLE; abort has priority over a beat offered in the same cycle, which is not accepted.
- DONE: lasts one cycle, then IDLE.

Write rules:
- Write outputs are registered.
- Both `bram_addr_*_ext` and both `bram_wdata_*_ext` carry the same registered address and data.
- Only the selected target's `bram_we_*_ext` equals the latched `in_mask` of the accepted beat. The unselected target's enable is always 0.
- In cycles with no accepted beat, both `we` are 0; addr and wdata hold their last value.
- `in_mask`=0 still consumes a row slot and advances the address.

Status and boundary rules:
- `start` while not IDLE is ignored; the latched config is unchanged.
- `busy`=1 in LOAD and DONE.
- `done` is asserted in the DONE cycle only. It is not asserted on abort.
- `reset` asserted mid-transfer: all state and outputs clear immediately. Rows already written stay in the BRAM.

## Timing
Reset values:
- All outputs are 0.
- FSM is in IDLE.

Cycle behaviour:
- `start` in cycle T → `busy`=1 and `in_ready`=1 from T+1.
- A beat accepted in cycle N → its write (addr, wdata, we) is visible in N+1.
- The last beat accepted in N → DONE, `done`=1 and `busy`=1 in N+1, coinciding with the final write. `in_ready`=0 from N+1; IDLE in N+2.
- `num_rows`=0 with `start` in T → `done`=1 in T+1, no writes.
- Maximum throughput is one row per cycle; stalls on `in_valid`=0 are unbounded.
- `in_ready` is a decode of the state register only; there is no combinational path from `in_valid`.

## Structure
- Shared TPU package holds:
  - `DWIDTH`, `MAT_MUL_SIZE`, `AWIDTH`, `MASK_WIDTH`, `ADDR_STRIDE_WIDTH`
  - the FSM state enum (IDLE, LOAD, DONE)
- One sub-module, `stride_addr_gen`:
  - loads the base on start and adds the stride on each accepted beat;
  - keeps a down-counter of remaining rows and produces `last` when the remaining count is 1.
- The top of this block holds the FSM, the output registers and the A/B select.

## Test plan
- base 0x010, stride 4, num_rows 3, target A, beats in consecutive cycles, mask 0xF → writes at 0x010, 0x014, 0x018 on A. `bram_we_b_ext` stays 0. `done` coincides with the 0x018 write.
- target B, base 0x3FE, stride 1, num_rows 3 → addresses 0x3FE, 0x3FF, 0x000 (wrap). Only `bram_we_b_ext` active.
- num_rows 0 → `done` one cycle after `start`; no `we` ever asserted; `in_ready` never 1.
- `in_valid` toggled every other cycle, num_rows 4, mask pattern 0x1, 0x0, 0x8, 0xF → 4 writes with those exact `we` values, addresses advancing on each, including the 0x0-mask beat.
- `abort` after 2 of 5 beats, together with a valid beat → 2 writes only; offered beat not accepted; no `done`. A new `start` then runs normally from its own base.
- `reset` asserted asynchronously between clock edges mid-transfer → all outputs 0 before the next edge. A second `start` issued while busy has no effect.
